// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl
//   HH:MM BCD timekeeper and front-panel sequencer for a 24-hour clock.
//   A prescaler divides clk down to a one-minute tick while in RUN mode;
//   mode_btn walks the set modes and inc_btn bumps the selected field.
//   Optional feature macro: ALARM_CTRL_EN (alarm-time registers, two extra
//   set modes and a registered alarm output). Without it, alarm is tied 0.
module clock_time_ctrl #(
    parameter int TICK_DIV = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       alarm_arm,
    output logic [3:0] min_units,
    output logic [2:0] min_tens,
    output logic [3:0] hr_units,
    output logic [2:0] hr_tens,
    output logic [2:0] mode,
    output logic       tick,
    output logic       alarm
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        SET_HR     = 3'd1,
        SET_MIN    = 3'd2,
        SET_AL_HR  = 3'd3,
        SET_AL_MIN = 3'd4
    } mode_t;

    mode_t            state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       mu_q, mu_d;
    logic [2:0]       mt_q, mt_d;
    logic [3:0]       hu_q, hu_d;
    logic [2:0]       ht_q, ht_d;
    logic             tick_q, tick_d;
    logic [7:0]       min_nx;
    logic [6:0]       hr_nx;
    logic             edit;

    // Minute +1 in BCD. Result is {carry, tens, units}; 59 wraps to 00 with carry.
    function automatic logic [7:0] bcd_min_inc(input logic [2:0] tens, input logic [3:0] units);
        logic [7:0] r;
        if (units != 4'd9)
            r = {1'b0, tens, units + 4'd1};
        else if (tens != 3'd5)
            r = {1'b0, tens + 3'd1, 4'd0};
        else
            r = 8'h00 | 8'h80;
        return r;
    endfunction

    // Hour +1 in BCD, modulo 24. Result is {tens, units}.
    function automatic logic [6:0] bcd_hr_inc(input logic [2:0] tens, input logic [3:0] units);
        logic [6:0] r;
        if (tens == 3'd2 && units == 4'd3)
            r = 7'd0;
        else if (units != 4'd9)
            r = {tens, units + 4'd1};
        else
            r = {tens + 3'd1, 4'd0};
        return r;
    endfunction

    assign min_nx = bcd_min_inc(mt_q, mu_q);
    assign hr_nx  = bcd_hr_inc(ht_q, hu_q);

    // A simultaneous mode press wins over an increment press.
    assign edit = inc_btn & ~mode_btn;

    // Mode state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next mode: one step per mode_btn pulse around the set-mode ring.
    always_comb begin
        state_d = state_q;
        if (mode_btn) begin
            case (state_q)
                RUN:        state_d = SET_HR;
                SET_HR:     state_d = SET_MIN;
`ifdef ALARM_CTRL_EN
                SET_MIN:    state_d = SET_AL_HR;
                SET_AL_HR:  state_d = SET_AL_MIN;
`else
                SET_MIN:    state_d = RUN;
`endif
                default:    state_d = RUN;
            endcase
        end
    end

    // Prescaler, tick and time-of-day next values.
    always_comb begin
        pre_d  = '0;
        tick_d = 1'b0;
        mu_d   = mu_q;
        mt_d   = mt_q;
        hu_d   = hu_q;
        ht_d   = ht_q;
        case (state_q)
            RUN: begin
                if (pre_q == PRE_LAST) begin
                    tick_d       = 1'b1;
                    {mt_d, mu_d} = min_nx[6:0];
                    if (min_nx[7]) {ht_d, hu_d} = hr_nx;
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
                // Leaving RUN freezes the prescaler at zero.
                if (mode_btn) pre_d = '0;
            end
            SET_HR: begin
                if (edit) {ht_d, hu_d} = hr_nx;
            end
            SET_MIN: begin
                // Minute edit wraps 59->00 without touching the hour.
                if (edit) {mt_d, mu_d} = min_nx[6:0];
            end
            default: ;
        endcase
    end

    // Time, prescaler and tick registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            mu_q   <= 4'd0;
            mt_q   <= 3'd0;
            hu_q   <= 4'd0;
            ht_q   <= 3'd0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            mu_q   <= mu_d;
            mt_q   <= mt_d;
            hu_q   <= hu_d;
            ht_q   <= ht_d;
            tick_q <= tick_d;
        end
    end

`ifdef ALARM_CTRL_EN
    logic [3:0] amu_q, amu_d;
    logic [2:0] amt_q, amt_d;
    logic [3:0] ahu_q, ahu_d;
    logic [2:0] aht_q, aht_d;
    logic [7:0] al_min_nx;
    logic [6:0] al_hr_nx;
    logic       alarm_q, alarm_d;

    assign al_min_nx = bcd_min_inc(amt_q, amu_q);
    assign al_hr_nx  = bcd_hr_inc(aht_q, ahu_q);

    // Alarm-time edits and alarm match, evaluated on the displayed time.
    always_comb begin
        amu_d   = amu_q;
        amt_d   = amt_q;
        ahu_d   = ahu_q;
        aht_d   = aht_q;
        if (edit && state_q == SET_AL_HR)  {aht_d, ahu_d} = al_hr_nx;
        if (edit && state_q == SET_AL_MIN) {amt_d, amu_d} = al_min_nx[6:0];
        alarm_d = (state_q == RUN) && alarm_arm &&
                  (mu_q == amu_q) && (mt_q == amt_q) &&
                  (hu_q == ahu_q) && (ht_q == aht_q);
    end

    // Alarm-time and alarm output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            amu_q   <= 4'd0;
            amt_q   <= 3'd0;
            ahu_q   <= 4'd0;
            aht_q   <= 3'd0;
            alarm_q <= 1'b0;
        end else begin
            amu_q   <= amu_d;
            amt_q   <= amt_d;
            ahu_q   <= ahu_d;
            aht_q   <= aht_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm_arm;
    assign unused_alarm_arm = alarm_arm;
    assign alarm            = 1'b0;
`endif

    assign min_units = mu_q;
    assign min_tens  = mt_q;
    assign hr_units  = hu_q;
    assign hr_tens   = ht_q;
    assign mode      = state_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl
//   Table vectors, directed corner sequences and random button traffic for
//   clock_time_ctrl (TICK_DIV=4), checked against a minutes-of-day model.
module tb_clock_time_ctrl;

    localparam int DIV = 4;
`ifdef ALARM_CTRL_EN
    localparam int NMODES = 5;
`else
    localparam int NMODES = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_btn, inc_btn, alarm_arm;
    logic [3:0] min_units, hr_units;
    logic [2:0] min_tens, hr_tens, mode;
    logic       tick, alarm;

    clock_time_ctrl #(.TICK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .alarm_arm(alarm_arm), .min_units(min_units), .min_tens(min_tens),
        .hr_units(hr_units), .hr_tens(hr_tens), .mode(mode), .tick(tick),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: time and alarm time as minutes since midnight.
    int   m_min, m_pre, m_mode, m_al;
    logic m_tick, m_alarm;
    int   tick_cnt, wide_cnt, al_cnt;
    logic prev_tick;

    typedef struct {
        logic mb;
        logic ib;
        int   e_mode;
        int   e_min;
        logic e_tick;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_minutes();
        return (int'(hr_tens) * 10 + int'(hr_units)) * 60 + int'(min_tens) * 10 + int'(min_units);
    endfunction

    function automatic int dut_vec();
        return int'({mode, hr_tens, hr_units, min_tens, min_units, tick, alarm});
    endfunction

    function automatic int exp_vec();
        int h, m;
        h = m_min / 60;
        m = m_min % 60;
        return int'({3'(m_mode), 3'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), m_tick, m_alarm});
    endfunction

    task automatic model_reset();
        m_min = 0; m_pre = 0; m_mode = 0; m_al = 0;
        m_tick = 1'b0; m_alarm = 1'b0;
    endtask

    task automatic model_edge(input logic mb, input logic ib, input logic arm);
        logic nal;
        nal    = (m_mode == 0) && arm && (m_min == m_al);
        m_tick = 1'b0;
        if (m_mode == 0) begin
            if (m_pre == DIV - 1) begin
                m_pre  = 0;
                m_min  = (m_min + 1) % 1440;
                m_tick = 1'b1;
            end else begin
                m_pre++;
            end
        end
        if (mb) begin
            m_mode = (m_mode + 1) % NMODES;
            m_pre  = 0;
        end else if (ib) begin
            case (m_mode)
                1: m_min = ((m_min / 60 + 1) % 24) * 60 + m_min % 60;
                2: m_min = (m_min / 60) * 60 + (m_min % 60 + 1) % 60;
                3: m_al  = ((m_al / 60 + 1) % 24) * 60 + m_al % 60;
                4: m_al  = (m_al / 60) * 60 + (m_al % 60 + 1) % 60;
                default: ;
            endcase
        end
`ifdef ALARM_CTRL_EN
        m_alarm = nal;
`else
        m_alarm = 1'b0;
`endif
    endtask

    task automatic step(input logic mb, input logic ib);
        mode_btn = mb;
        inc_btn  = ib;
        @(posedge clk);
        model_edge(mb, ib, alarm_arm);
        #1;
        chk("cycle", dut_vec(), exp_vec());
        if (tick) tick_cnt++;
        if (tick && prev_tick) wide_cnt++;
        if (alarm) al_cnt++;
        prev_tick = tick;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", dut_vec(), 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold", dut_vec(), 0);
        reset = 1'b1;
        prev_tick = 1'b0;
    endtask

    // From RUN: set hour and minute via the buttons; leaves the DUT in SET_MIN.
    task automatic set_time(input int h, input int m);
        int n;
        step(1'b1, 1'b0);
        n = (h - m_min / 60 + 24) % 24;
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n = (m - m_min % 60 + 60) % 60;
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    task automatic goto_run();
        for (int i = 0; i < NMODES && m_mode != 0; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1, 0,   1'b0};
        tbl[1] = '{1'b0, 1'b1, 1, 60,  1'b0};
        tbl[2] = '{1'b0, 1'b1, 1, 120, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 2, 120, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 2, 121, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 2, 121, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 2, 122, 1'b0};
        tbl[7] = '{1'b1, 1'b0, (NMODES == 5) ? 3 : 0, 122, 1'b0};

        reset = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; alarm_arm = 1'b0;
        prev_tick = 1'b0; tick_cnt = 0; wide_cnt = 0; al_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), 0);
        reset = 1'b1;

        // 240 cycles of RUN: one hour, sixty single-cycle ticks.
        tick_cnt = 0; wide_cnt = 0;
        for (int i = 0; i < 240; i++) step(1'b0, 1'b0);
        chk("t1_time", dut_minutes(), 60);
        chk("t1_ticks", tick_cnt, 60);
        chk("t1_tick_width", wide_cnt, 0);

        // Table vectors from a fresh reset.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].mb, tbl[i].ib);
            chk("vec_mode", int'(mode), tbl[i].e_mode);
            chk("vec_time", dut_minutes(), tbl[i].e_min);
            chk("vec_tick", int'(tick), int'(tbl[i].e_tick));
        end
        goto_run();

        // 23:59 rolls to 00:00 exactly DIV cycles after returning to RUN.
        set_time(23, 59);
        goto_run();
        tick_cnt = 0;
        repeat (DIV - 1) step(1'b0, 1'b0);
        chk("t2_hold", dut_minutes(), 1439);
        step(1'b0, 1'b0);
        chk("t2_midnight", dut_minutes(), 0);
        chk("t2_tick", tick_cnt, 1);
        set_time(9, 59);
        goto_run();
        repeat (DIV) step(1'b0, 1'b0);
        chk("t2_ten", dut_minutes(), 600);

        // Edit-mode wraps do not carry.
        set_time(5, 59);
        step(1'b0, 1'b1);
        chk("t3_min_wrap", dut_minutes(), 300);
        goto_run();
        set_time(23, 10);
        goto_run();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("t3_hr_wrap", dut_minutes(), 10);
        goto_run();

        // Same-cycle presses and inc in RUN.
        step(1'b1, 1'b1);
        chk("t4_mode", int'(mode), 1);
        chk("t4_hold", dut_minutes(), 10);
        goto_run();
        step(1'b0, 1'b1);
        chk("t4_run_inc", dut_minutes(), 10);

        // Reset in the middle of SET_MIN.
        set_time(12, 34);
        chk("t5_pre", dut_minutes(), 754);
        apply_reset();
        tick_cnt = 0;
        repeat (DIV - 1) step(1'b0, 1'b0);
        chk("t5_no_tick", tick_cnt, 0);
        step(1'b0, 1'b0);
        chk("t5_first_tick", int'(tick), 1);
        chk("t5_time", dut_minutes(), 1);

`ifdef ALARM_CTRL_EN
        // Alarm at 00:02, armed: high for the four cycles following 00:02 display.
        apply_reset();
        alarm_arm = 1'b1;
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        al_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0);
            if (i == 8) chk("t6_before", int'(alarm), 0);
            if (i == 9) chk("t6_rise", int'(alarm), 1);
            if (i == 13) chk("t6_fall", int'(alarm), 0);
        end
        chk("t6_width", al_cnt, 4);
        apply_reset();
        alarm_arm = 1'b0;
        al_cnt = 0;
        repeat (8) step(1'b0, 1'b0);
        chk("t6_disarmed", al_cnt, 0);
`else
        // Without the alarm feature, arming never raises alarm.
        alarm_arm = 1'b1;
        apply_reset();
        al_cnt = 0;
        repeat (8) step(1'b0, 1'b0);
        chk("alarm_tied", al_cnt, 0);
`endif

        // Random button traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            alarm_arm = 1'($urandom % 2);
            step(1'(($urandom % 12) == 0), 1'(($urandom % 3) == 0));
        end
        goto_run();
        for (int i = 0; i < 300; i++) begin
            alarm_arm = 1'($urandom % 2);
            step(1'(($urandom % 40) == 0), 1'(($urandom % 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
